// File: rtl/rv_ctrl_pkg.sv
// Shared types and encodings for the RV32I bit-sliced control sequencer.
// Holds opcodes, FSM states, immediate formats and datapath mux encodings.
package rv_ctrl_pkg;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OP_IMM = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111
    } opcode_e;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_TRAP
    } state_e;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } imm_fmt_t;

    localparam logic [2:0] RD_MUX_ALU   = 3'b000;
    localparam logic [2:0] RD_MUX_SHIFT = 3'b001;
    localparam logic [2:0] RD_MUX_CMP   = 3'b010;
    localparam logic [2:0] RD_MUX_IMM   = 3'b011;
    localparam logic [2:0] RD_MUX_PCP4  = 3'b100;
    localparam logic [2:0] RD_MUX_MEM   = 3'b101;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_XOR = 2'b01;
    localparam logic [1:0] ALU_OR  = 2'b10;
    localparam logic [1:0] ALU_AND = 2'b11;

    // Halfword stores ignore addr_lo[0] so the mask always covers an aligned lane pair.
    function automatic logic [3:0] store_mask(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b00:   store_mask = 4'b0001 << addr_lo;
            2'b01:   store_mask = 4'b0011 << {addr_lo[1], 1'b0};
            default: store_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/rv_ctrl_fsm_imm_decode.sv
// Combinational immediate extraction and legality check for one RV32I word.
// The format is chosen from the opcode; every immediate sign-extends from ir[31].
module rv_imm_decode
    import rv_ctrl_pkg::*;
(
    input  logic [31:0] ir,
    output logic [31:0] imm,
    output logic        legal
);

    imm_fmt_t   fmt;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];

    always_comb begin
        fmt   = FMT_R;
        legal = 1'b0;
        case (ir[6:0])
            OPC_LOAD: begin
                fmt   = FMT_I;
                legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
            end
            OPC_STORE: begin
                fmt   = FMT_S;
                legal = (funct3 <= 3'b010);
            end
            OPC_OP_IMM: begin
                fmt = FMT_I;
                case (funct3)
                    3'b001:  legal = (funct7 == 7'b0000000);
                    3'b101:  legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    default: legal = 1'b1;
                endcase
            end
            OPC_OP: begin
                fmt   = FMT_R;
                legal = (funct7 == 7'b0000000) ||
                        ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            OPC_BRANCH: begin
                fmt   = FMT_B;
                legal = (funct3 != 3'b010) && (funct3 != 3'b011);
            end
            OPC_JALR: begin
                fmt   = FMT_I;
                legal = (funct3 == 3'b000);
            end
            OPC_JAL: begin
                fmt   = FMT_J;
                legal = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt   = FMT_U;
                legal = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (fmt)
            FMT_I:   imm = {{20{ir[31]}}, ir[31:20]};
            FMT_S:   imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            FMT_B:   imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            FMT_U:   imm = {ir[31:12], 12'b0};
            FMT_J:   imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: imm = 32'b0;
        endcase
    end

endmodule

// File: rtl/rv_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM sequencer driving the 32-slice RV32I datapath.
// Register selects and immediate are registered in DECODE; EXEC/MEM controls are decoded from ir.
module rv_ctrl_fsm
    import rv_ctrl_pkg::*;
#(
    parameter int NUM_REGS        = 32,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    input  logic                imem_resp,
    input  logic [31:0]         imem_rdata,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [3:0]          dmem_wmask,
    input  logic                dmem_resp,
    input  logic [1:0]          dmem_addr_lo,
    input  logic                cmp_eq,
    input  logic                cmp_lt,
    output logic [NUM_REGS-1:0] rs1_sel,
    output logic [NUM_REGS-1:0] rs2_sel,
    output logic [NUM_REGS-1:0] rd_sel,
    output logic [31:0]         imm,
    output logic [2:0]          rd_mux_sel,
    output logic [2:0]          mem_mux_sel,
    output logic [1:0]          alu_op,
    output logic                alu_inv_rs2,
    output logic                alu_cin,
    output logic                alu_mux_1_sel,
    output logic                alu_mux_2_sel,
    output logic                cmp_mux_sel,
    output logic                cmp_signed,
    output logic                shift_dir,
    output logic                shift_arith,
    output logic                shamt_imm_sel,
    output logic                pc_mux_sel,
    output logic                pc_we,
    output logic                trap
);

    state_e              state_q, state_d;
    logic [31:0]         ir_q, ir_d;
    logic [31:0]         imm_q, imm_d;
    logic [NUM_REGS-1:0] rs1_sel_q, rs1_sel_d;
    logic [NUM_REGS-1:0] rs2_sel_q, rs2_sel_d;
    logic [31:0]         dec_imm;
    logic                dec_legal;
    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic [NUM_REGS-1:0] rd_onehot;
    logic                is_load, is_store, is_imm_op, br_taken;

    rv_imm_decode u_imm_decode (
        .ir    (ir_q),
        .imm   (dec_imm),
        .legal (dec_legal)
    );

    assign opcode    = ir_q[6:0];
    assign funct3    = ir_q[14:12];
    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_imm_op = (opcode == OPC_OP_IMM);
    // x0 is hardwired: never enable its write, the PC update still happens.
    assign rd_onehot = (ir_q[11:7] == 5'd0) ? '0 : (NUM_REGS'(1) << ir_q[11:7]);
    // funct3[2] picks lt over eq, funct3[0] inverts for BNE/BGE/BGEU.
    assign br_taken  = (funct3[2] ? cmp_lt : cmp_eq) ^ funct3[0];

    assign rs1_sel = rs1_sel_q;
    assign rs2_sel = rs2_sel_q;
    assign imm     = imm_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            ir_q      <= '0;
            imm_q     <= '0;
            rs1_sel_q <= '0;
            rs2_sel_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            imm_q     <= imm_d;
            rs1_sel_q <= rs1_sel_d;
            rs2_sel_q <= rs2_sel_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        imm_d     = imm_q;
        rs1_sel_d = rs1_sel_q;
        rs2_sel_d = rs2_sel_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_resp) begin
                    ir_d    = imem_rdata;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                rs1_sel_d = NUM_REGS'(1) << ir_q[19:15];
                rs2_sel_d = NUM_REGS'(1) << ir_q[24:20];
                imm_d     = dec_imm;
                state_d   = (!dec_legal && HALT_ON_ILLEGAL) ? ST_TRAP : ST_EXEC;
            end
            ST_EXEC:  state_d = (dec_legal && (is_load || is_store)) ? ST_MEM : ST_FETCH;
            ST_MEM:   if (dmem_resp) state_d = ST_FETCH;
            ST_TRAP:  state_d = ST_TRAP;
            default:  state_d = ST_FETCH;
        endcase
    end

    always_comb begin
        imem_req      = (state_q == ST_FETCH);
        trap          = (state_q == ST_TRAP);
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        dmem_wmask    = 4'b0;
        rd_sel        = '0;
        rd_mux_sel    = RD_MUX_ALU;
        mem_mux_sel   = 3'b0;
        alu_op        = ALU_ADD;
        alu_inv_rs2   = 1'b0;
        alu_cin       = 1'b0;
        alu_mux_1_sel = 1'b0;
        alu_mux_2_sel = 1'b0;
        cmp_mux_sel   = 1'b0;
        cmp_signed    = 1'b0;
        shift_dir     = 1'b0;
        shift_arith   = 1'b0;
        shamt_imm_sel = 1'b0;
        pc_mux_sel    = 1'b0;
        pc_we         = 1'b0;

        if (state_q == ST_EXEC && dec_legal) begin
            case (opcode)
                OPC_OP, OPC_OP_IMM: begin
                    rd_sel        = rd_onehot;
                    pc_we         = 1'b1;
                    alu_mux_2_sel = is_imm_op;
                    cmp_mux_sel   = is_imm_op;
                    shamt_imm_sel = is_imm_op;
                    case (funct3)
                        3'b000: begin
                            alu_inv_rs2 = !is_imm_op && ir_q[30];
                            alu_cin     = !is_imm_op && ir_q[30];
                        end
                        3'b001: rd_mux_sel = RD_MUX_SHIFT;
                        3'b010: begin
                            rd_mux_sel = RD_MUX_CMP;
                            cmp_signed = 1'b1;
                        end
                        3'b011: rd_mux_sel = RD_MUX_CMP;
                        3'b100: alu_op = ALU_XOR;
                        3'b101: begin
                            rd_mux_sel  = RD_MUX_SHIFT;
                            shift_dir   = 1'b1;
                            shift_arith = ir_q[30];
                        end
                        3'b110: alu_op = ALU_OR;
                        default: alu_op = ALU_AND;
                    endcase
                end
                OPC_LUI: begin
                    rd_sel     = rd_onehot;
                    pc_we      = 1'b1;
                    rd_mux_sel = RD_MUX_IMM;
                end
                OPC_AUIPC: begin
                    rd_sel        = rd_onehot;
                    pc_we         = 1'b1;
                    alu_mux_1_sel = 1'b1;
                    alu_mux_2_sel = 1'b1;
                end
                OPC_JAL, OPC_JALR: begin
                    rd_sel        = rd_onehot;
                    pc_we         = 1'b1;
                    rd_mux_sel    = RD_MUX_PCP4;
                    pc_mux_sel    = 1'b1;
                    alu_mux_1_sel = (opcode == OPC_JAL);
                    alu_mux_2_sel = 1'b1;
                end
                OPC_BRANCH: begin
                    alu_mux_1_sel = 1'b1;
                    alu_mux_2_sel = 1'b1;
                    cmp_signed    = (funct3[2:1] == 2'b10);
                    pc_mux_sel    = br_taken;
                    pc_we         = 1'b1;
                end
                OPC_LOAD, OPC_STORE: alu_mux_2_sel = 1'b1;
                default: ;
            endcase
        end else if (state_q == ST_EXEC) begin
            pc_we = 1'b1;
        end

        // Address operands stay selected for the whole access so alu_out is stable.
        if (state_q == ST_MEM) begin
            dmem_req      = 1'b1;
            alu_mux_2_sel = 1'b1;
            dmem_we       = is_store;
            dmem_wmask    = is_store ? store_mask(funct3, dmem_addr_lo) : 4'b0;
            if (dmem_resp) begin
                pc_we = 1'b1;
                if (is_load) begin
                    rd_sel      = rd_onehot;
                    rd_mux_sel  = RD_MUX_MEM;
                    mem_mux_sel = funct3;
                end
            end
        end
    end

endmodule

// File: tb/tb_rv_ctrl_fsm.sv
// Directed bench for rv_ctrl_fsm: drives on the falling edge, samples just after it.
// Each scenario task carries its own hand-computed expectations.
module tb_rv_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_resp;
    logic [31:0] imem_rdata;
    logic        dmem_req, dmem_we, dmem_resp;
    logic [3:0]  dmem_wmask;
    logic [1:0]  dmem_addr_lo;
    logic        cmp_eq, cmp_lt;
    logic [31:0] rs1_sel, rs2_sel, rd_sel, imm;
    logic [2:0]  rd_mux_sel, mem_mux_sel;
    logic [1:0]  alu_op;
    logic        alu_inv_rs2, alu_cin, alu_mux_1_sel, alu_mux_2_sel, cmp_mux_sel, cmp_signed;
    logic        shift_dir, shift_arith, shamt_imm_sel, pc_mux_sel, pc_we, trap;

    int errors = 0;
    int checks = 0;

    rv_ctrl_fsm #(.NUM_REGS(32), .HALT_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_resp(imem_resp), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_wmask(dmem_wmask),
        .dmem_resp(dmem_resp), .dmem_addr_lo(dmem_addr_lo),
        .cmp_eq(cmp_eq), .cmp_lt(cmp_lt),
        .rs1_sel(rs1_sel), .rs2_sel(rs2_sel), .rd_sel(rd_sel), .imm(imm),
        .rd_mux_sel(rd_mux_sel), .mem_mux_sel(mem_mux_sel), .alu_op(alu_op),
        .alu_inv_rs2(alu_inv_rs2), .alu_cin(alu_cin),
        .alu_mux_1_sel(alu_mux_1_sel), .alu_mux_2_sel(alu_mux_2_sel),
        .cmp_mux_sel(cmp_mux_sel), .cmp_signed(cmp_signed),
        .shift_dir(shift_dir), .shift_arith(shift_arith), .shamt_imm_sel(shamt_imm_sel),
        .pc_mux_sel(pc_mux_sel), .pc_we(pc_we), .trap(trap)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // Starts in FETCH on a falling edge; returns one tick into EXEC.
    task automatic fetch(input logic [31:0] word, input int wait_cycles);
        imem_resp  = 1'b0;
        imem_rdata = 32'hFFFF_FFFF;
        repeat (wait_cycles) @(negedge clk);
        imem_resp  = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_resp  = 1'b0;
        imem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_resp = 1'b0; imem_rdata = '0; dmem_resp = 1'b0;
        dmem_addr_lo = 2'b0; cmp_eq = 1'b0; cmp_lt = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_imem_req got=%b exp=1", imem_req); end
        checks++;
        if ({dmem_req, dmem_we, dmem_wmask, rs1_sel, rs2_sel, rd_sel, imm, rd_mux_sel, mem_mux_sel, alu_op,
             alu_inv_rs2, alu_cin, alu_mux_1_sel, alu_mux_2_sel, cmp_mux_sel, cmp_signed, shift_dir,
             shift_arith, shamt_imm_sel, pc_mux_sel, pc_we, trap} !== '0) begin
            errors++; $display("FAIL reset_outputs_zero got rd_sel=%h imm=%h pc_we=%b trap=%b", rd_sel, imm, pc_we, trap);
        end
    endtask

    task automatic test_addi();
        imem_resp = 1'b0; imem_rdata = 32'hFFFF_FFFF;
        repeat (2) begin
            @(negedge clk); #1;
            checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL addi_fetch_hold got=%b exp=1", imem_req); end
        end
        imem_resp = 1'b1; imem_rdata = 32'h0050_0093;
        @(negedge clk);
        imem_resp = 1'b0; imem_rdata = 32'hFFFF_FFFF;
        #1;
        checks++; if ({imem_req, pc_we} !== 2'b00) begin errors++; $display("FAIL addi_decode_idle got=%b exp=00", {imem_req, pc_we}); end
        @(negedge clk); #1;
        checks++; if (imm !== 32'd5) begin errors++; $display("FAIL addi_imm got=%h exp=%h", imm, 32'd5); end
        checks++; if (rs1_sel !== 32'h1) begin errors++; $display("FAIL addi_rs1_sel got=%h exp=%h", rs1_sel, 32'h1); end
        checks++; if (rs2_sel !== 32'h20) begin errors++; $display("FAIL addi_rs2_sel got=%h exp=%h", rs2_sel, 32'h20); end
        checks++; if (rd_sel !== 32'h2) begin errors++; $display("FAIL addi_rd_sel got=%h exp=%h", rd_sel, 32'h2); end
        checks++; if ({rd_mux_sel, alu_mux_2_sel, pc_we, alu_inv_rs2} !== 6'b000_1_1_0) begin
            errors++; $display("FAIL addi_ctrl got=%b exp=000110", {rd_mux_sel, alu_mux_2_sel, pc_we, alu_inv_rs2});
        end
        @(negedge clk); #1;
        checks++; if ({imem_req, pc_we, rd_sel} !== {2'b10, 32'h0}) begin
            errors++; $display("FAIL addi_back_to_fetch got imem_req=%b pc_we=%b rd_sel=%h exp 1 0 0", imem_req, pc_we, rd_sel);
        end
    endtask

    task automatic test_branch();
        cmp_eq = 1'b1; cmp_lt = 1'b0;
        fetch(32'h0020_8463, 0);
        checks++; if (imm !== 32'd8) begin errors++; $display("FAIL beq_imm got=%h exp=%h", imm, 32'd8); end
        checks++; if ({pc_mux_sel, pc_we, alu_mux_1_sel, alu_mux_2_sel, cmp_signed} !== 5'b11110) begin
            errors++; $display("FAIL beq_taken_ctrl got=%b exp=11110", {pc_mux_sel, pc_we, alu_mux_1_sel, alu_mux_2_sel, cmp_signed});
        end
        checks++; if (rd_sel !== 32'h0) begin errors++; $display("FAIL beq_rd_sel got=%h exp=0", rd_sel); end
        @(negedge clk);
        cmp_eq = 1'b0;
        fetch(32'h0020_8463, 1);
        checks++; if ({pc_mux_sel, pc_we} !== 2'b01) begin errors++; $display("FAIL beq_not_taken got=%b exp=01", {pc_mux_sel, pc_we}); end
        @(negedge clk);
        cmp_lt = 1'b1;
        fetch(32'h0020_C463, 0);
        checks++; if ({pc_mux_sel, cmp_signed, pc_we} !== 3'b111) begin errors++; $display("FAIL blt_taken got=%b exp=111", {pc_mux_sel, cmp_signed, pc_we}); end
        @(negedge clk);
        cmp_lt = 1'b0;
    endtask

    task automatic test_load();
        int req_cnt = 0;
        dmem_resp = 1'b0;
        fetch(32'h0000_A183, 1);
        checks++; if ({dmem_req, pc_we, rd_sel} !== {2'b00, 32'h0}) begin
            errors++; $display("FAIL lw_exec got dmem_req=%b pc_we=%b rd_sel=%h exp 0 0 0", dmem_req, pc_we, rd_sel);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            dmem_resp = (i == 3);
            #1;
            if (dmem_req === 1'b1) req_cnt++;
            if (i < 3) begin
                checks++; if ({rd_sel, pc_we, dmem_we} !== 34'h0) begin
                    errors++; $display("FAIL lw_wait%0d got rd_sel=%h pc_we=%b we=%b exp 0", i, rd_sel, pc_we, dmem_we);
                end
            end else begin
                checks++; if (rd_sel !== 32'h8) begin errors++; $display("FAIL lw_rd_sel got=%h exp=%h", rd_sel, 32'h8); end
                checks++; if ({rd_mux_sel, mem_mux_sel, pc_we, dmem_we} !== 8'b101_010_1_0) begin
                    errors++; $display("FAIL lw_resp_ctrl got=%b exp=10101010", {rd_mux_sel, mem_mux_sel, pc_we, dmem_we});
                end
            end
        end
        @(negedge clk);
        dmem_resp = 1'b0;
        #1;
        checks++; if (req_cnt !== 4) begin errors++; $display("FAIL lw_req_cycles got=%0d exp=4", req_cnt); end
        checks++; if ({dmem_req, imem_req, rd_sel} !== {2'b01, 32'h0}) begin
            errors++; $display("FAIL lw_after got dmem_req=%b imem_req=%b rd_sel=%h exp 0 1 0", dmem_req, imem_req, rd_sel);
        end
    endtask

    task automatic test_store();
        logic [31:0] words [3] = '{32'h0020_8023, 32'h0020_9023, 32'h0020_A023};
        logic [1:0]  los   [3] = '{2'd2, 2'd3, 2'd1};
        logic [3:0]  masks [3] = '{4'b0100, 4'b1100, 4'b1111};
        for (int k = 0; k < 3; k++) begin
            dmem_addr_lo = los[k];
            dmem_resp = 1'b0;
            fetch(words[k], 0);
            @(negedge clk); #1;
            checks++; if ({dmem_req, dmem_we, dmem_wmask} !== {2'b11, masks[k]}) begin
                errors++; $display("FAIL store%0d_wait got req/we/mask=%b exp=%b", k, {dmem_req, dmem_we, dmem_wmask}, {2'b11, masks[k]});
            end
            @(negedge clk);
            dmem_resp = 1'b1;
            #1;
            checks++; if ({pc_we, rd_sel, dmem_wmask} !== {1'b1, 32'h0, masks[k]}) begin
                errors++; $display("FAIL store%0d_resp got pc_we=%b rd_sel=%h mask=%b exp 1 0 %b", k, pc_we, rd_sel, dmem_wmask, masks[k]);
            end
            @(negedge clk);
            dmem_resp = 1'b0;
        end
        dmem_addr_lo = 2'd0;
    endtask

    task automatic test_alu_ops();
        fetch(32'h4073_02B3, 0);
        checks++; if ({alu_inv_rs2, alu_cin, alu_mux_2_sel, alu_op} !== 5'b11000) begin
            errors++; $display("FAIL sub_ctrl got=%b exp=11000", {alu_inv_rs2, alu_cin, alu_mux_2_sel, alu_op});
        end
        checks++; if (rd_sel !== 32'h20) begin errors++; $display("FAIL sub_rd_sel got=%h exp=%h", rd_sel, 32'h20); end
        @(negedge clk);
        fetch(32'h0010_0013, 0);
        checks++; if ({rd_sel, pc_we} !== {32'h0, 1'b1}) begin errors++; $display("FAIL x0_dest got rd_sel=%h pc_we=%b exp 0 1", rd_sel, pc_we); end
        @(negedge clk);
        fetch(32'hFFF0_0093, 0);
        checks++; if ({imm, alu_inv_rs2} !== {32'hFFFF_FFFF, 1'b0}) begin errors++; $display("FAIL addi_neg got imm=%h inv=%b exp ffffffff 0", imm, alu_inv_rs2); end
        @(negedge clk);
        fetch(32'h1234_5137, 0);
        checks++; if ({imm, rd_mux_sel, rd_sel} !== {32'h1234_5000, 3'b011, 32'h4}) begin
            errors++; $display("FAIL lui got imm=%h rd_mux=%b rd_sel=%h exp 12345000 011 4", imm, rd_mux_sel, rd_sel);
        end
        @(negedge clk);
    endtask

    task automatic test_illegal();
        imem_resp = 1'b1; imem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        #1;
        checks++; if (trap !== 1'b0) begin errors++; $display("FAIL illegal_decode_trap got=%b exp=0", trap); end
        @(negedge clk); #1;
        checks++; if ({trap, imem_req, pc_we, rd_sel} !== {3'b100, 32'h0}) begin
            errors++; $display("FAIL illegal_trap got trap=%b imem_req=%b pc_we=%b rd_sel=%h exp 1 0 0 0", trap, imem_req, pc_we, rd_sel);
        end
        repeat (3) begin
            @(negedge clk); #1;
            checks++; if ({trap, imem_req} !== 2'b10) begin errors++; $display("FAIL illegal_hold got=%b exp=10", {trap, imem_req}); end
        end
        imem_resp = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if ({trap, imem_req} !== 2'b01) begin errors++; $display("FAIL illegal_rst_recover got=%b exp=01", {trap, imem_req}); end
    endtask

    task automatic test_reset_in_mem();
        dmem_resp = 1'b0;
        fetch(32'h0000_A183, 0);
        @(negedge clk); #1;
        checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rstmem_in_mem got=%b exp=1", dmem_req); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if ({dmem_req, imem_req, rd_sel, pc_we} !== {2'b01, 32'h0, 1'b0}) begin
            errors++; $display("FAIL rstmem_abort got dmem_req=%b imem_req=%b rd_sel=%h pc_we=%b exp 0 1 0 0", dmem_req, imem_req, rd_sel, pc_we);
        end
        dmem_resp = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            checks++; if ({rd_sel, pc_we, dmem_req} !== 34'h0) begin
                errors++; $display("FAIL rstmem_no_pulse got rd_sel=%h pc_we=%b dmem_req=%b exp 0", rd_sel, pc_we, dmem_req);
            end
        end
        dmem_resp = 1'b0;
        fetch(32'h0050_0093, 0);
        checks++; if (rd_sel !== 32'h2) begin errors++; $display("FAIL rstmem_resume got=%h exp=%h", rd_sel, 32'h2); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_addi();
        test_branch();
        test_load();
        test_store();
        test_alu_ops();
        test_illegal();
        test_reset_in_mem();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
